// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
//    Moore controller that sequences the 16-bit datapath (register file,
//    shifter, ALU and status register) through one instruction per start pulse.
//    The opcode and op fields are captured when the FSM leaves WAIT. Later
//    changes on the instruction register do not affect the instruction in flight.
//
// Ports
//    clk     in   1  rising-edge clock
//    reset   in   1  synchronous active-low reset
//    s       in   1  start, sampled only in WAIT
//    opcode  in   3  IR[15:13]
//    op      in   2  IR[12:11]
//    w       out  1  high while idle in WAIT
//    nsel    out  3  one-hot regfile select: 001 Rm, 010 Rd, 100 Rn
//    vsel    out  2  writeback source: 00 datapath C, 01 sign-extended imm8
//    write   out  1  regfile write enable
//    loada   out  1  load A register
//    loadb   out  1  load B register
//    asel    out  1  force ALU A input to zero
//    bsel    out  1  ALU B from immediate (always 0 here)
//    loadc   out  1  load C register
//    loads   out  1  load status register
//    halt    out  1  HALT indicator, present only with ILLEGAL_TRAP_EN
//
// Build option
//    ILLEGAL_TRAP_EN : illegal encodings trap into HALT, which only reset can
//                      leave. Without it, illegal encodings retire as a NOP.

module cpu_ctrl_fsm #(
   parameter logic [2:0] OPC_ALU = 3'b101,
   parameter logic [2:0] OPC_MOV = 3'b110
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic       w,
   output logic [2:0] nsel,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       asel,
   output logic       bsel,
   output logic       loadc,
`ifdef ILLEGAL_TRAP_EN
   output logic       loads,
   output logic       halt
`else
   output logic       loads
`endif
);

   typedef enum logic [3:0] {
      stWait,
      stDecode,
      stWrImm,
      stGetA,
      stGetB,
      stExec,
      stWrReg,
`ifdef ILLEGAL_TRAP_EN
      stCmp,
      stHalt
`else
      stCmp
`endif
   } stateT;

   stateT      state, stateNext;
   logic [2:0] opcReg;
   logic [1:0] opReg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= stWait;
         opcReg <= '0;
         opReg  <= '0;
      end else begin
         state <= stateNext;
         if (state == stWait && s) begin
            opcReg <= opcode;
            opReg  <= op;
         end
      end
   end

   always_comb begin
      stateNext = state;
      w         = 1'b0;
      nsel      = '0;
      vsel      = '0;
      write     = 1'b0;
      loada     = 1'b0;
      loadb     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      halt      = 1'b0;
`endif
      unique case (state)
         stWait: begin
            w = 1'b1;
            if (s) stateNext = stDecode;
         end
         stDecode: begin
            // Any encoding not matched below is illegal: it traps or retires as a NOP.
`ifdef ILLEGAL_TRAP_EN
            stateNext = stHalt;
`else
            stateNext = stWait;
`endif
            if (opcReg == OPC_ALU) begin
               stateNext = stGetA;
            end else if (opcReg == OPC_MOV) begin
               if (opReg == 2'b10)      stateNext = stWrImm;
               else if (opReg == 2'b00) stateNext = stGetA;
            end
         end
         stWrImm: begin
            nsel      = 3'b100;
            vsel      = 2'b01;
            write     = 1'b1;
            stateNext = stWait;
         end
         stGetA: begin
            nsel      = 3'b100;
            loada     = 1'b1;
            stateNext = stGetB;
         end
         stGetB: begin
            nsel      = 3'b001;
            loadb     = 1'b1;
            stateNext = (opcReg == OPC_ALU && opReg == 2'b01) ? stCmp : stExec;
         end
         stExec: begin
            // Only MOV register reaches EXEC with the MOV opcode; zeroing A
            // turns the ALU add into a pass-through of B.
            loadc     = 1'b1;
            asel      = (opcReg == OPC_MOV);
            stateNext = stWrReg;
         end
         stWrReg: begin
            nsel      = 3'b010;
            vsel      = 2'b00;
            write     = 1'b1;
            stateNext = stWait;
         end
         stCmp: begin
            loads     = 1'b1;
            stateNext = stWait;
         end
`ifdef ILLEGAL_TRAP_EN
         stHalt: begin
            halt      = 1'b1;
            stateNext = stHalt;
         end
`endif
         default: stateNext = stWait;
      endcase
   end

endmodule
